regfile_fifo_ctrl: RTL

REGFILE_FIFO_CTRL -- requirements
Module: regfile_fifo_ctrl

---
 rtl/regfile_fifo_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_fifo_ctrl.sv
// FIFO controller over an external register file with a registered output stage.
// Define REGFILE_FIFO_CTRL_LEVEL_EN to expose the occupancy count on port COUNT.
module regfile_fifo_ctrl #(
    parameter int unsigned addr_width = 2,
    parameter int unsigned data_width = 8,
    parameter int unsigned depth      = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ENQ,
    input  logic [data_width-1:0] D_IN,
    output logic                  FULL_N,
    input  logic                  DEQ,
    output logic [data_width-1:0] D_OUT,
    output logic                  EMPTY_N,
    input  logic                  CLR,
    output logic [addr_width-1:0] RF_ADDR_IN,
    output logic [data_width-1:0] RF_D_IN,
    output logic                  RF_WE,
    output logic [addr_width-1:0] RF_ADDR_1,
`ifdef REGFILE_FIFO_CTRL_LEVEL_EN
    output logic [addr_width:0]   COUNT,
`endif
    input  logic [data_width-1:0] RF_D_OUT_1
);

    localparam int unsigned CW = addr_width + 1;
    localparam logic [CW-1:0]         FULL_CNT = CW'(depth + 1);
    localparam logic [addr_width-1:0] LAST_PTR = addr_width'(depth - 1);

    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;

    logic enq_ok, deq_ok, stor_empty, out_free, bypass, refill, rf_we;

    function automatic logic [addr_width-1:0] ptr_incr(input logic [addr_width-1:0] p);
        return (p == LAST_PTR) ? '0 : p + addr_width'(1);
    endfunction

    // Accept/route decisions; storage holds count-1 entries whenever the output register is valid.
    always_comb begin
        enq_ok     = ENQ & full_n_q & ~CLR;
        deq_ok     = DEQ & empty_n_q & ~CLR;
        stor_empty = (count_q <= CW'(1));
        out_free   = ~empty_n_q | deq_ok;
        bypass     = stor_empty & out_free;
        refill     = ~stor_empty & out_free & ~CLR;
        rf_we      = enq_ok & ~bypass & RST_N;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dout_d    = dout_q;
        empty_n_d = empty_n_q;
        full_n_d  = full_n_q;
        if (CLR) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            empty_n_d = 1'b0;
            full_n_d  = 1'b1;
        end else begin
            if (rf_we) begin
                wr_ptr_d = ptr_incr(wr_ptr_q);
            end
            if (refill) begin
                dout_d   = RF_D_OUT_1;
                rd_ptr_d = ptr_incr(rd_ptr_q);
            end else if (enq_ok && bypass) begin
                dout_d = D_IN;
            end
            count_d   = count_q + CW'(enq_ok) - CW'(deq_ok);
            empty_n_d = (count_d != '0);
            full_n_d  = (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dout_q    <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dout_q    <= dout_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
        end
    end

    assign FULL_N     = full_n_q;
    assign EMPTY_N    = empty_n_q;
    assign D_OUT      = dout_q;
    assign RF_WE      = rf_we;
    assign RF_ADDR_IN = wr_ptr_q;
    assign RF_D_IN    = D_IN;
    assign RF_ADDR_1  = rd_ptr_q;
`ifdef REGFILE_FIFO_CTRL_LEVEL_EN
    assign COUNT      = count_q;
`endif

endmodule
